// File: rtl/ram64_arbiter.sv
// Round-robin arbiter sharing one 64x16 RAM64 between clients A and B.
// After reset an optional clear pass zero-fills every word before requests are served.
module ram64_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [5:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [5:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [5:0]  ram_address,
    input  logic [15:0] ram_out,
    output logic        busy
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_SERVE = 1'b1} state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        last_q, last_d;      // 1'b1 = B was granted last
    logic        a_rvalid_q, a_rvalid_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        a_gnt_s, b_gnt_s;

    // Grant selection; gated by rst_n so no grant is ever visible during reset
    always_comb begin
        a_gnt_s = 1'b0;
        b_gnt_s = 1'b0;
        if (rst_n && (state_q == ST_SERVE)) begin
            if (a_req && b_req) begin
                if (last_q) begin
                    a_gnt_s = 1'b1;
                end else begin
                    b_gnt_s = 1'b1;
                end
            end else begin
                a_gnt_s = a_req;
                b_gnt_s = b_req;
            end
        end else begin
            a_gnt_s = 1'b0;
            b_gnt_s = 1'b0;
        end
    end

    // RAM port drive; load is masked by rst_n so reset never writes the array
    always_comb begin
        ram_in      = 16'h0000;
        ram_load    = 1'b0;
        ram_address = 6'd0;
        if (state_q == ST_CLEAR) begin
            ram_load    = rst_n;
            ram_address = cnt_q;
        end else if (a_gnt_s) begin
            ram_load    = a_we;
            ram_address = a_addr;
            ram_in      = a_we ? a_wdata : 16'h0000;
        end else if (b_gnt_s) begin
            ram_load    = b_we;
            ram_address = b_addr;
            ram_in      = b_we ? b_wdata : 16'h0000;
        end else begin
            ram_in      = 16'h0000;
        end
    end

    // Next-state: clear counter, round-robin pointer and read-return registers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == 6'd63) begin
                    state_d = ST_SERVE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_SERVE: begin
                if (a_gnt_s) begin
                    last_d = 1'b0;
                    if (!a_we) begin
                        a_rvalid_d = 1'b1;
                        a_rdata_d  = ram_out;
                    end else begin
                        a_rvalid_d = 1'b0;
                    end
                end else if (b_gnt_s) begin
                    last_d = 1'b1;
                    if (!b_we) begin
                        b_rvalid_d = 1'b1;
                        b_rdata_d  = ram_out;
                    end else begin
                        b_rvalid_d = 1'b0;
                    end
                end else begin
                    last_d = last_q;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            cnt_q      <= 6'd0;
            last_q     <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= 16'h0000;
            b_rdata_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt    = a_gnt_s;
    assign b_gnt    = b_gnt_s;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: doc/ram64_arbiter.md
# ram64_arbiter

Two-requester controller that shares one 64×16 RAM64 between client A and client B, with round-robin arbitration and a registered read-return path. After reset it runs a clear sequence that writes zero to all 64 words before it accepts any request. It sits between the RAM64 instance and two independent datapath clients, and is the only driver of the RAM's `in`, `load` and `address` inputs.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default 1: 1 = run the 64-cycle zero-fill after reset; 0 = start directly in SERVE.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `a_req` input 1: client A request; held with its fields until `a_gnt` is sampled high.
- `a_we` input 1: 1 = write, 0 = read.
- `a_addr` input 6: word address.
- `a_wdata` input 16: write data.
- `a_gnt` output 1: combinational grant; the transaction completes on this clock edge.
- `a_rvalid` output 1: registered one-cycle pulse, read data valid.
- `a_rdata` output 16: registered read data; holds until A's next read returns.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the A ports, for client B.
- `ram_in` output 16: drives RAM64 `in`.
- `ram_load` output 1: drives RAM64 `load`.
- `ram_address` output 6: drives RAM64 `address`.
- `ram_out` input 16: RAM64 `out`; combinational read of `ram_address`.
- `busy` output 1: high while in CLEAR.

## Operation
- FSM states:
  - CLEAR: 6-bit counter `cnt` counts 0..63. Drive `ram_load`=1, `ram_in`=0, `ram_address`=`cnt`. Both grants are 0.
    - When `cnt`==63, go to SERVE on the next edge.
    - Reset state when `CLEAR_ON_RESET`=1.
  - SERVE: arbitration, described below. Reset state when `CLEAR_ON_RESET`=0.
- Arbitration in SERVE, combinational on the current cycle's requests:
  - Only one `req` high: grant that client.
  - Both high: grant the client that was not granted last, tracked by the `last` register.
  - `last` reset value = B, so A wins the first tie.
  - `last` updates to the granted client on every grant.
- Granted write: `ram_load`=1, `ram_address`=addr, `ram_in`=wdata. The word is written at that edge.
- Granted read: `ram_load`=0, `ram_address`=addr.
  - At that edge, `ram_out` is captured into the granted client's `rdata`.
  - That client's `rvalid` is 1 for the following cycle only.
- No grant: `ram_load`=0, `ram_address`=0, `ram_in`=0.
- The other client's `rdata` and `rvalid` are unaffected by a grant.
- `ram_load` is forced to 0 while `rst_n`=0, so the RAM is never written during reset.

## Timing
- Reset values:
  - `a_gnt`/`b_gnt`=0, `a_rvalid`/`b_rvalid`=0, `a_rdata`/`b_rdata`=0, `ram_load`=0.
  - `busy`=1 if `CLEAR_ON_RESET`=1, else 0.
  - `cnt`=0, `last`=B.
- CLEAR lasts exactly 64 cycles after `rst_n` deasserts.
  - First grant is possible in cycle 64, counting the first post-reset cycle as 0.
  - `busy` falls at the start of cycle 64.
- Requests seen during CLEAR are not granted. Requesters keep them held, and they are served in the first SERVE cycle.
- Grant: same cycle as `req` in SERVE, zero latency. At most one grant per cycle.
- Read latency: data and `rvalid` are visible one cycle after the grant cycle.
- Throughput: one transaction per cycle in total.
  - A single client requesting every cycle is granted every cycle.
  - Both clients requesting continuously are granted alternately A,B,A,B…
- Write at edge k followed by a read of the same address granted in cycle k+1 returns the new data, from either client.
- Back-to-back reads by one client: `rvalid` stays high across consecutive cycles, with new `rdata` each cycle.
- `rst_n` asserted at any point, mid-CLEAR or mid-SERVE:
  - All registers go to their reset values immediately.
  - A pending `rvalid` is dropped.
  - The full 64-word clear restarts on release.
- An address at 63 wraps nothing; `cnt` terminates at 63 and never wraps into a second clear pass.

## Test plan
- Reset release with `CLEAR_ON_RESET`=1 → `busy`=1 for 64 cycles, `ram_load`=1 with addresses 0..63 in order, then `busy`=0. A subsequent read of address 37 returns 0x0000.
- A writes 0x1234 to address 5, then A reads address 5 → `a_gnt`=1 in both cycles, `a_rvalid`=1 one cycle after the read grant, `a_rdata`=0x1234, `b_rvalid` stays 0.
- A and B both hold requests for 6 cycles (A reads addresses 0..2, B writes 0xBEEF to addresses 10..12) → grants go A,B,A,B,A,B; afterwards reads of addresses 10..12 return 0xBEEF.
- B writes 0x00FF to address 63 in cycle k, A reads address 63 in cycle k+1 → `a_rdata`=0x00FF at cycle k+2.
- `rst_n` pulsed low during cycle 30 of CLEAR, and again one cycle after a read grant → `ram_load` is 0 during reset, the pending `rvalid` never appears, and CLEAR restarts at address 0 for a full 64 cycles.
- `CLEAR_ON_RESET`=0 → `busy`=0 from reset release, and a request in the first post-reset cycle is granted that cycle.
